// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the banked register file.
// Optional feature macro: REG_FILE_BYPASS_EN (write-through read forwarding).
package reg_file_pkg;

   localparam int DEF_NUM_REGS  = 12;
   localparam int DEF_REG_WIDTH = 8;
   localparam int DEF_NUM_BANKS = 2;
   localparam int DEF_CAR_REG   = 11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      COPY = 2'd1,
      DONE = 2'd2
   } copy_state_e;

   // Index width that never collapses to zero bits.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reg_file_banked_copy_ctrl.sv
// Bank-to-bank copy sequencer: walks registers 1..NUM_REGS-1,
// one per cycle, then pulses copy_done for a single cycle.
module reg_copy_ctrl
   import reg_file_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = idx_width(DEF_NUM_REGS),
   parameter int BANK_W   = idx_width(DEF_NUM_BANKS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              copy_req,
   input  logic [BANK_W-1:0] copy_src,
   input  logic [BANK_W-1:0] copy_dst,
   output logic              copy_busy,
   output logic              copy_done,
   output logic              cp_we,
   output logic [BANK_W-1:0] cp_src,
   output logic [BANK_W-1:0] cp_bank,
   output logic [ADDR_W-1:0] cp_idx
);

   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);
   localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);

   copy_state_e       state;
   copy_state_e       state_n;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] idx_n;
   logic [BANK_W-1:0] src;
   logic [BANK_W-1:0] src_n;
   logic [BANK_W-1:0] dst;
   logic [BANK_W-1:0] dst_n;

   // State, index and latched banks; reset aborts any copy in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= FIRST;
         src   <= '0;
         dst   <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         src   <= src_n;
         dst   <= dst_n;
      end
   end

   // Next-state: a self-copy has nothing to move, so it skips to DONE.
   always_comb begin
      state_n = state;
      idx_n   = idx;
      src_n   = src;
      dst_n   = dst;
      unique case (state)
         IDLE: begin
            if (copy_req) begin
               if (copy_src != copy_dst) begin
                  src_n   = copy_src;
                  dst_n   = copy_dst;
                  idx_n   = FIRST;
                  state_n = COPY;
               end else begin
                  state_n = DONE;
               end
            end
         end
         COPY: begin
            if (idx == LAST) begin
               idx_n   = FIRST;
               state_n = DONE;
            end else begin
               idx_n = idx + FIRST;
            end
         end
         DONE: state_n = IDLE;
         default: begin
            state_n = IDLE;
            idx_n   = FIRST;
         end
      endcase
   end

   // Copy-side write port toward the storage array.
   always_comb begin
      copy_busy = (state == COPY);
      copy_done = (state == DONE);
      cp_we     = (state == COPY);
      cp_src    = src;
      cp_bank   = dst;
      cp_idx    = idx;
   end

endmodule

// File: rtl/reg_file_banked.sv
// Banked register file: zero reg, carry reg, 3 read ports, copy engine.
// Optional feature macro: REG_FILE_BYPASS_EN (write-through read forwarding).
module reg_file_banked
   import reg_file_pkg::*;
#(
   parameter int NUM_REGS  = DEF_NUM_REGS,
   parameter int REG_WIDTH = DEF_REG_WIDTH,
   parameter int NUM_BANKS = DEF_NUM_BANKS,
   parameter int CAR_REG   = DEF_CAR_REG,
   parameter int ADDR_W    = idx_width(NUM_REGS),
   parameter int BANK_W    = idx_width(NUM_BANKS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [BANK_W-1:0]    bank_sel,
   input  logic                 reg_write,
   input  logic [ADDR_W-1:0]    rd_addr,
   input  logic [ADDR_W-1:0]    rt_addr,
   input  logic [ADDR_W-1:0]    rs_addr,
   input  logic [REG_WIDTH-1:0] rd_in,
   input  logic                 car_write,
   input  logic [REG_WIDTH-1:0] car_in,
   output logic [REG_WIDTH-1:0] rt_out,
   output logic [REG_WIDTH-1:0] rs_out,
   output logic [REG_WIDTH-1:0] rd_out,
   input  logic                 copy_req,
   input  logic [BANK_W-1:0]    copy_src,
   input  logic [BANK_W-1:0]    copy_dst,
   output logic                 copy_busy,
   output logic                 copy_done
);

   logic [REG_WIDTH-1:0] mem [NUM_BANKS][NUM_REGS];

   logic                 cp_we;
   logic [BANK_W-1:0]    cp_src;
   logic [BANK_W-1:0]    cp_bank;
   logic [ADDR_W-1:0]    cp_idx;
   logic [REG_WIDTH-1:0] cp_data;

   reg_copy_ctrl #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .BANK_W   (BANK_W)
   ) u_copy (
      .clk       (clk),
      .rst_n     (rst_n),
      .copy_req  (copy_req),
      .copy_src  (copy_src),
      .copy_dst  (copy_dst),
      .copy_busy (copy_busy),
      .copy_done (copy_done),
      .cp_we     (cp_we),
      .cp_src    (cp_src),
      .cp_bank   (cp_bank),
      .cp_idx    (cp_idx)
   );

   // Stored value at (bank, addr); out-of-range or r0 gives zero.
   function automatic logic [REG_WIDTH-1:0] lookup(
      input logic [BANK_W-1:0] b,
      input logic [ADDR_W-1:0] a
   );
      logic [REG_WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         for (int j = 1; j < NUM_REGS; j++) begin
            if (b == BANK_W'(i) && a == ADDR_W'(j)) begin
               v = mem[i][j];
            end
         end
      end
      return v;
   endfunction

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      assign mem[b][0] = '0;
      for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
         localparam logic [BANK_W-1:0] BI = BANK_W'(b);
         localparam logic [ADDR_W-1:0] RI = ADDR_W'(r);
         localparam bit                IS_CAR = (r == CAR_REG);

         logic                 hit_cp;
         logic                 hit_rd;
         logic                 hit_car;
         logic [REG_WIDTH-1:0] q;

         assign hit_cp  = cp_we && cp_bank == BI && cp_idx == RI;
         assign hit_rd  = reg_write && bank_sel == BI && rd_addr == RI;
         assign hit_car = IS_CAR && car_write && bank_sel == BI;

         // Carry beats rd, and any architectural write beats the copy.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               q <= '0;
            end else if (hit_car) begin
               q <= car_in;
            end else if (hit_rd) begin
               q <= rd_in;
            end else if (hit_cp) begin
               q <= cp_data;
            end
         end

         assign mem[b][r] = q;
      end
   end

`ifdef REG_FILE_BYPASS_EN
   logic bank_ok;

   // Forward same-cycle writes to a matching read address.
   function automatic logic [REG_WIDTH-1:0] fwd(
      input logic [ADDR_W-1:0]    a,
      input logic [REG_WIDTH-1:0] base
   );
      logic [REG_WIDTH-1:0] v;
      v = base;
      if (bank_ok && a != '0 && a < ADDR_W'(NUM_REGS)) begin
         if (reg_write && rd_addr == a) begin
            v = rd_in;
         end
         if (car_write && a == ADDR_W'(CAR_REG)) begin
            v = car_in;
         end
      end
      return v;
   endfunction

   // Active bank must exist for a write to land.
   always_comb begin
      bank_ok = 1'b0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         if (bank_sel == BANK_W'(i)) begin
            bank_ok = 1'b1;
         end
      end
   end

   // Read muxes with write-through forwarding.
   always_comb begin
      rt_out = fwd(rt_addr, lookup(bank_sel, rt_addr));
      rs_out = fwd(rs_addr, lookup(bank_sel, rs_addr));
      rd_out = fwd(rd_addr, lookup(bank_sel, rd_addr));
   end
`else
   // Read muxes return the stored value only.
   always_comb begin
      rt_out = lookup(bank_sel, rt_addr);
      rs_out = lookup(bank_sel, rs_addr);
      rd_out = lookup(bank_sel, rd_addr);
   end
`endif

   // Copy source read always sees stored state, never forwarded data.
   always_comb begin
      cp_data = lookup(cp_src, cp_idx);
   end

endmodule

// File: tb/tb_reg_file_banked.sv
// Self-checking bench for reg_file_banked against an array model.
// Honours REG_FILE_BYPASS_EN when the bundle is built with it.
module tb_reg_file_banked;

   localparam int NR  = 12;
   localparam int NB  = 2;
   localparam int CAR = 11;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [0:0] bank_sel;
   logic       reg_write;
   logic [3:0] rd_addr;
   logic [3:0] rt_addr;
   logic [3:0] rs_addr;
   logic [7:0] rd_in;
   logic       car_write;
   logic [7:0] car_in;
   logic [7:0] rt_out;
   logic [7:0] rs_out;
   logic [7:0] rd_out;
   logic       copy_req;
   logic [0:0] copy_src;
   logic [0:0] copy_dst;
   logic       copy_busy;
   logic       copy_done;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] m [NB][NR];
   bit         mbusy;
   bit         mdone;
   int         cidx;
   int         csrc;
   int         cdst;

   reg_file_banked dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bank_sel  (bank_sel),
      .reg_write (reg_write),
      .rd_addr   (rd_addr),
      .rt_addr   (rt_addr),
      .rs_addr   (rs_addr),
      .rd_in     (rd_in),
      .car_write (car_write),
      .car_in    (car_in),
      .rt_out    (rt_out),
      .rs_out    (rs_out),
      .rd_out    (rd_out),
      .copy_req  (copy_req),
      .copy_src  (copy_src),
      .copy_dst  (copy_dst),
      .copy_busy (copy_busy),
      .copy_done (copy_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, run did not finish");
      $fatal(1, "watchdog");
   end

   function automatic void model_clear();
      for (int b = 0; b < NB; b++) begin
         for (int r = 0; r < NR; r++) begin
            m[b][r] = 8'h00;
         end
      end
      mbusy = 1'b0;
      mdone = 1'b0;
      cidx  = 1;
   endfunction

   // Expected read value at address a in the currently selected bank.
   function automatic logic [7:0] exp_rd(input int a);
      logic [7:0] v;
      int b;
      v = 8'h00;
      b = int'(bank_sel);
      if (a >= 1 && a < NR && b < NB) begin
         v = m[b][a];
`ifdef REG_FILE_BYPASS_EN
         if (reg_write && int'(rd_addr) == a) v = rd_in;
         if (car_write && a == CAR) v = car_in;
`endif
      end
      return v;
   endfunction

   // One clock edge; model applies copy step, then architectural writes.
   task automatic tick();
      logic [7:0] old [NB][NR];
      bit nd;
      int b;
      int a;
      old = m;
      b = int'(bank_sel);
      a = int'(rd_addr);
      @(posedge clk);
      if (rst_n) begin
         if (mbusy) m[cdst][cidx] = old[csrc][cidx];
         if (reg_write && b < NB && a >= 1 && a < NR) m[b][a] = rd_in;
         if (car_write && b < NB) m[b][CAR] = car_in;
         nd = 1'b0;
         if (mbusy) begin
            if (cidx == NR - 1) begin
               mbusy = 1'b0;
               nd    = 1'b1;
            end else begin
               cidx++;
            end
         end else if (!mdone && copy_req) begin
            if (copy_src != copy_dst) begin
               mbusy = 1'b1;
               cidx  = 1;
               csrc  = int'(copy_src);
               cdst  = int'(copy_dst);
            end else begin
               nd = 1'b1;
            end
         end
         mdone = nd;
      end
      #1;
   endtask

   task automatic idle_inputs();
      reg_write = 1'b0;
      car_write = 1'b0;
      copy_req  = 1'b0;
      rd_addr   = 4'd0;
      rd_in     = 8'h00;
      car_in    = 8'h00;
   endtask

   task automatic write_reg(input int b, input int a, input logic [7:0] d);
      bank_sel  = 1'(b);
      reg_write = 1'b1;
      rd_addr   = 4'(a);
      rd_in     = d;
      tick();
      reg_write = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_clear();
      bank_sel = 1'b0;
      rt_addr = 4'd3;
      rs_addr = 4'd0;
      copy_src = 1'b0;
      copy_dst = 1'b0;
      idle_inputs();
      tick();
      tick();
      rst_n = 1'b1;
      #2;
      vectors++;
      if (copy_busy !== 1'b0 || copy_done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_flags: busy=%b done=%b want 0 0",
                  copy_busy, copy_done);
      end
      write_reg(0, 3, 8'hA5);
      write_reg(1, 3, 8'h3C);
      for (int b = 0; b < NB; b++) begin
         bank_sel = 1'(b);
         #1;
         vectors++;
         if (rt_out !== exp_rd(3)) begin
            miscompares++;
            $display("FAIL prewrite_r3 b%0d: got %h want %h",
                     b, rt_out, exp_rd(3));
         end
      end
      rst_n = 1'b0;
      model_clear();
      #2;
      for (int b = 0; b < NB; b++) begin
         bank_sel = 1'(b);
         #1;
         vectors++;
         if (rt_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_r3 b%0d: got %h want 00", b, rt_out);
         end
      end
      vectors++;
      if (copy_busy !== 1'b0 || copy_done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_pulse_flags: busy=%b done=%b want 0 0",
                  copy_busy, copy_done);
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_zero_carry();
      write_reg(0, 0, 8'hFF);
      rt_addr = 4'd0;
      #2;
      vectors++;
      if (rt_out !== 8'h00) begin
         miscompares++;
         $display("FAIL zero_reg: got %h want 00", rt_out);
      end
      bank_sel  = 1'b0;
      reg_write = 1'b1;
      rd_addr   = 4'd11;
      rd_in     = 8'h12;
      car_write = 1'b1;
      car_in    = 8'h34;
      tick();
      idle_inputs();
      rt_addr = 4'd11;
      #2;
      vectors++;
      if (rt_out !== 8'h34) begin
         miscompares++;
         $display("FAIL carry_wins: got %h want 34", rt_out);
      end
      write_reg(0, 13, 8'h99);
      for (int a = 12; a < 16; a++) begin
         rs_addr = 4'(a);
         #1;
         vectors++;
         if (rs_out !== 8'h00) begin
            miscompares++;
            $display("FAIL oob_read a%0d: got %h want 00", a, rs_out);
         end
      end
   endtask

   task automatic test_copy();
      int busy_n;
      int done_n;
      for (int r = 1; r < NR; r++) write_reg(0, r, 8'(8'h10 + r - 1));
      copy_src = 1'b0;
      copy_dst = 1'b1;
      copy_req = 1'b1;
      tick();
      copy_req = 1'b0;
      busy_n = 0;
      done_n = 0;
      for (int j = 1; j <= 14; j++) begin
         reg_write = 1'b0;
         copy_req  = 1'b0;
         if (j == 3) begin
            bank_sel = 1'b0;
            reg_write = 1'b1;
            rd_addr = 4'd2;
            rd_in = 8'h77;
         end
         if (j == 5) begin
            bank_sel = 1'b1;
            reg_write = 1'b1;
            rd_addr = 4'd5;
            rd_in = 8'hEE;
         end
         if (j == 4) begin
            copy_req = 1'b1;
            copy_src = 1'b1;
            copy_dst = 1'b0;
         end
         #2;
         if (copy_busy) busy_n++;
         if (copy_done) done_n++;
         vectors++;
         if (copy_busy !== mbusy || copy_done !== mdone) begin
            miscompares++;
            $display("FAIL copy_flags j%0d: busy=%b done=%b want %b %b",
                     j, copy_busy, copy_done, mbusy, mdone);
         end
         tick();
      end
      idle_inputs();
      vectors++;
      if (busy_n != NR - 1 || done_n != 1) begin
         miscompares++;
         $display("FAIL copy_len: busy=%0d done=%0d want 11 1",
                  busy_n, done_n);
      end
      bank_sel = 1'b1;
      for (int r = 0; r < NR; r++) begin
         logic [7:0] want;
         want = (r == 0) ? 8'h00 : 8'(8'h10 + r - 1);
         if (r == 5) want = 8'hEE;
         rt_addr = 4'(r);
         #1;
         vectors++;
         if (rt_out !== want) begin
            miscompares++;
            $display("FAIL copy_b1_r%0d: got %h want %h", r, rt_out, want);
         end
      end
   endtask

   task automatic test_bypass();
      write_reg(0, 4, 8'h33);
      bank_sel  = 1'b0;
      rt_addr   = 4'd4;
      reg_write = 1'b1;
      rd_addr   = 4'd4;
      rd_in     = 8'h5A;
      #2;
      vectors++;
`ifdef REG_FILE_BYPASS_EN
      if (rt_out !== 8'h5A) begin
         miscompares++;
         $display("FAIL bypass_r4: got %h want 5a", rt_out);
      end
`else
      if (rt_out !== 8'h33) begin
         miscompares++;
         $display("FAIL nobypass_r4: got %h want 33", rt_out);
      end
`endif
      tick();
      idle_inputs();
      #2;
      vectors++;
      if (rt_out !== 8'h5A) begin
         miscompares++;
         $display("FAIL r4_after: got %h want 5a", rt_out);
      end
      rs_addr   = 4'd11;
      reg_write = 1'b1;
      rd_addr   = 4'd11;
      rd_in     = 8'hA1;
      car_write = 1'b1;
      car_in    = 8'hC3;
      #2;
      vectors++;
      if (rs_out !== exp_rd(11)) begin
         miscompares++;
         $display("FAIL fwd_car: got %h want %h", rs_out, exp_rd(11));
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_abort();
      int done_n;
      copy_src = 1'b0;
      copy_dst = 1'b1;
      copy_req = 1'b1;
      tick();
      copy_req = 1'b0;
      for (int j = 1; j < 6; j++) tick();
      rst_n = 1'b0;
      model_clear();
      #2;
      vectors++;
      if (copy_busy !== 1'b0 || copy_done !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_flags: busy=%b done=%b want 0 0",
                  copy_busy, copy_done);
      end
      tick();
      tick();
      rst_n = 1'b1;
      done_n = 0;
      for (int j = 0; j < 15; j++) begin
         #2;
         if (copy_done) done_n++;
         tick();
      end
      vectors++;
      if (done_n != 0) begin
         miscompares++;
         $display("FAIL abort_done: got %0d pulses want 0", done_n);
      end
      for (int b = 0; b < NB; b++) begin
         for (int r = 0; r < NR; r++) begin
            bank_sel = 1'(b);
            rt_addr  = 4'(r);
            #1;
            vectors++;
            if (rt_out !== 8'h00) begin
               miscompares++;
               $display("FAIL abort_clear b%0d r%0d: got %h want 00",
                        b, r, rt_out);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         bank_sel  = 1'($urandom_range(1));
         reg_write = 1'($urandom_range(1));
         car_write = ($urandom_range(3) == 0);
         rd_addr   = 4'($urandom_range(15));
         rt_addr   = 4'($urandom_range(15));
         rs_addr   = 4'($urandom_range(15));
         rd_in     = 8'($urandom);
         car_in    = 8'($urandom);
         copy_req  = ($urandom_range(7) == 0);
         copy_src  = 1'($urandom_range(1));
         copy_dst  = 1'($urandom_range(1));
         #2;
         vectors++;
         if (rt_out !== exp_rd(int'(rt_addr)) ||
             rs_out !== exp_rd(int'(rs_addr)) ||
             rd_out !== exp_rd(int'(rd_addr))) begin
            miscompares++;
            $display("FAIL rand_read n%0d: got %h %h %h want %h %h %h",
                     n, rt_out, rs_out, rd_out, exp_rd(int'(rt_addr)),
                     exp_rd(int'(rs_addr)), exp_rd(int'(rd_addr)));
         end
         vectors++;
         if (copy_busy !== mbusy || copy_done !== mdone) begin
            miscompares++;
            $display("FAIL rand_flags n%0d: busy=%b done=%b want %b %b",
                     n, copy_busy, copy_done, mbusy, mdone);
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_zero_carry();
      test_copy();
      test_bypass();
      test_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
